// File: rtl/vgachargen_map_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : vgachargen_map_sequencer
// Brief   : Arbitrates the single map RAM port between host word accesses and
//           the clear/scroll engine.
// Revision: 1.0 - initial release
// ============================================================================
module vgachargen_map_sequencer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [15:0]       host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [15:0]       host_rdata_o,
  input  logic              cmd_valid_i,
  input  logic [1:0]        cmd_op_i,
  input  logic [15:0]       cmd_fill_i,
  output logic              cmd_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] map_addr_o,
  output logic              map_wen_o,
  output logic [15:0]       map_wdata_o,
  input  logic [15:0]       map_rdata_i
);

  localparam logic [ADDR_W-1:0] c_CELLS     = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] c_LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] c_LAST_MOVE = ADDR_W'((ROWS - 1) * COLS - 1);
  localparam logic [ADDR_W-1:0] c_ROW_STEP  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] c_ONE       = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_SCR_RD   = 3'd2,
    S_SCR_WR   = 3'd3,
    S_SCR_LAST = 3'd4,
    S_DONE     = 3'd5
  } t_state;

  t_state              r_state;
  t_state              w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_nxt;
  logic [15:0]         r_fill;
  logic [15:0]         r_hold;
  logic                r_rd_pending;
  logic                r_eng_lost;
  logic                r_rvalid;
  logic                r_rd_inrange;
  logic [15:0]         r_rdata;
  logic [ADDR_W-1:0]   r_map_addr;

  logic                w_accept;
  logic                w_eng_req;
  logic                w_eng_win;
  logic                w_host_win;
  logic                w_host_inrange;
  logic [ADDR_W-1:0]   w_eng_addr;
  logic                w_eng_we;
  logic [15:0]         w_eng_wdata;
  logic [15:0]         w_host_rd;

  // Engine yields to the host unless it was starved on the previous cycle.
  always_comb begin
    w_eng_req      = (r_state == S_FILL) || (r_state == S_SCR_RD) ||
                     (r_state == S_SCR_WR) || (r_state == S_SCR_LAST);
    w_eng_win      = w_eng_req && (!host_req_i || r_eng_lost);
    w_host_win     = host_req_i && !w_eng_win;
    w_host_inrange = (host_addr_i < c_CELLS);
  end

  always_comb begin
    w_eng_addr  = r_idx;
    w_eng_we    = 1'b0;
    w_eng_wdata = 16'h0000;
    case (r_state)
      S_FILL, S_SCR_LAST: begin
        w_eng_we    = 1'b1;
        w_eng_wdata = r_fill;
      end
      S_SCR_RD: begin
        w_eng_addr = r_idx + c_ROW_STEP;
      end
      S_SCR_WR: begin
        w_eng_we    = 1'b1;
        // Read data is only on the bus the cycle after the read; later it lives in r_hold.
        w_eng_wdata = r_rd_pending ? map_rdata_i : r_hold;
      end
      default: begin
        w_eng_addr = r_idx;
      end
    endcase
  end

  always_comb begin
    map_addr_o  = r_map_addr;
    map_wen_o   = 1'b0;
    map_wdata_o = 16'h0000;
    if (w_eng_win) begin
      map_addr_o  = w_eng_addr;
      map_wen_o   = w_eng_we;
      map_wdata_o = w_eng_wdata;
    end else if (w_host_win && w_host_inrange) begin
      map_addr_o = host_addr_i;
      map_wen_o  = host_we_i;
      if (host_we_i) begin
        map_wdata_o = host_wdata_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_accept  = 1'b1;
          w_idx_nxt = '0;
          if (cmd_op_i == 2'b00) begin
            w_state_nxt = S_FILL;
          end else if (cmd_op_i == 2'b01) begin
            w_state_nxt = S_SCR_RD;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_FILL, S_SCR_LAST: begin
        if (w_eng_win) begin
          w_idx_nxt = r_idx + c_ONE;
          if (r_idx == c_LAST_CELL) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_SCR_RD: begin
        if (w_eng_win) begin
          w_state_nxt = S_SCR_WR;
        end
      end
      S_SCR_WR: begin
        if (w_eng_win) begin
          w_idx_nxt   = r_idx + c_ONE;
          w_state_nxt = (r_idx == c_LAST_MOVE) ? S_SCR_LAST : S_SCR_RD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_fill  <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_fill <= cmd_fill_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold       <= 16'h0000;
      r_rd_pending <= 1'b0;
      r_eng_lost   <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rd_inrange <= 1'b0;
      r_rdata      <= 16'h0000;
      r_map_addr   <= '0;
    end else begin
      r_rd_pending <= (r_state == S_SCR_RD) && w_eng_win;
      if (r_rd_pending) begin
        r_hold <= map_rdata_i;
      end
      r_eng_lost   <= w_eng_req && !w_eng_win;
      r_rvalid     <= w_host_win && !host_we_i;
      r_rd_inrange <= w_host_inrange;
      if (r_rvalid) begin
        r_rdata <= w_host_rd;
      end
      r_map_addr <= map_addr_o;
    end
  end

  assign w_host_rd     = r_rd_inrange ? map_rdata_i : 16'h0000;
  assign host_gnt_o    = w_host_win;
  assign host_rvalid_o = r_rvalid;
  assign host_rdata_o  = r_rvalid ? w_host_rd : r_rdata;
  assign cmd_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);

endmodule
`default_nettype wire
